// File: rtl/probe_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : probe_conditioner_pkg
//  Description : Shared types for the probe conditioner front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
package probe_conditioner_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'd0,
        MODE_DEBOUNCE = 2'd1,
        MODE_STRETCH  = 2'd2,
        MODE_RSVD     = 2'd3
    } probeMode_t;

endpackage
`default_nettype wire

// File: rtl/probe_conditioner_channel.sv
`default_nettype none
// ============================================================================
//  Module      : probe_conditioner_channel
//  Description : One probe channel: synchroniser, inversion, filter, edge pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module probe_conditioner_channel
    import probe_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   LIMIT_W     = 16,
    parameter logic INVERT      = 1'b0
)(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cg,
    input  logic               i_pin,
    input  logic [1:0]         i_mode,
    input  logic               i_mode_change,
    input  logic [LIMIT_W-1:0] i_limit,
    output logic               o_probe,
    output logic               o_rise,
    output logic               o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [LIMIT_W-1:0]     r_cnt;
    logic                   r_probe;
    logic                   r_prev;
    logic                   w_s;
    probeMode_t             w_mode;

    assign w_mode = probeMode_t'(i_mode);
    assign w_s    = r_sync[SYNC_STAGES-1] ^ INVERT;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_probe <= INVERT;
            r_prev  <= INVERT;
        end else if (i_cg) begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_probe;
            // A mode switch costs one cycle: counter restarts, level holds.
            if (i_mode_change) begin
                r_cnt <= '0;
            end else begin
                case (w_mode)
                    MODE_DEBOUNCE: begin
                        if (w_s == r_probe) begin
                            r_cnt <= '0;
                        end else if (r_cnt == i_limit) begin
                            r_probe <= w_s;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    MODE_STRETCH: begin
                        if (w_s) begin
                            r_probe <= 1'b1;
                            r_cnt   <= i_limit;
                        end else if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_probe <= 1'b0;
                        end
                    end
                    default: begin
                        r_probe <= w_s;
                    end
                endcase
            end
        end
    end

    assign o_probe = r_probe;
    assign o_rise  = i_cg &  r_probe & ~r_prev;
    assign o_fall  = i_cg & ~r_probe &  r_prev;

endmodule
`default_nettype wire

// File: rtl/probe_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : probe_conditioner
//  Description : N-channel probe front-end with mode register and activity flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module probe_conditioner
    import probe_conditioner_pkg::*;
#(
    parameter int                 N_PROBE     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 LIMIT_W     = 16,
    parameter logic [N_PROBE-1:0] INVERT_MASK = '0
)(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cg,
    input  logic [N_PROBE-1:0] i_probe,
    input  logic [1:0]         i_mode,
    input  logic [LIMIT_W-1:0] i_limit,
    input  logic               i_clearActivity,
    output logic [N_PROBE-1:0] o_probe,
    output logic [N_PROBE-1:0] o_rise,
    output logic [N_PROBE-1:0] o_fall,
    output logic [N_PROBE-1:0] o_activity
);

    probeMode_t         r_mode;
    logic               w_mode_change;
    logic [N_PROBE-1:0] r_activity;

    assign w_mode_change = (r_mode != probeMode_t'(i_mode));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode     <= MODE_BYPASS;
            r_activity <= '0;
        end else if (i_cg) begin
            r_mode     <= probeMode_t'(i_mode);
            // An edge in the same cycle as a clear still sets its flag.
            r_activity <= (r_activity & ~{N_PROBE{i_clearActivity}}) | o_rise | o_fall;
        end
    end

    assign o_activity = r_activity;

    generate
        for (genvar gi = 0; gi < N_PROBE; gi++) begin : g_channel
            probe_conditioner_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .LIMIT_W     (LIMIT_W),
                .INVERT      (INVERT_MASK[gi])
            ) u_channel (
                .i_clk         (i_clk),
                .i_rst         (i_rst),
                .i_cg          (i_cg),
                .i_pin         (i_probe[gi]),
                .i_mode        (r_mode),
                .i_mode_change (w_mode_change),
                .i_limit       (i_limit),
                .o_probe       (o_probe[gi]),
                .o_rise        (o_rise[gi]),
                .o_fall        (o_fall[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire
